updn_counter: RTL and testbench

UPDN_COUNTER -- requirements
Module: updn_counter

---
 rtl/updn_pkg.sv | 18 +
 rtl/updn_if.sv | 33 +++
 rtl/updn_cnt_core.sv | 73 +++++++
 rtl/updn_counter.sv | 98 +++++++++
 tb/tb_updn_counter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/updn_pkg.sv
// -----------------------------------------------------------------------------
// updn_pkg
// Shared definitions for the up/down counter block.
//   CNT_WIDTH_DEF : default counter width
//   state_t       : direction-FSM state encoding (IDLE, UP, DOWN, HOLD)
// -----------------------------------------------------------------------------
package updn_pkg;

    localparam int CNT_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/updn_if.sv
// -----------------------------------------------------------------------------
// updn_if
// Signal bundle for the up/down counter.
//   master modport : drives en, up_dn, load, load_val; observes the outputs
//   slave modport  : the counter side, receives controls, drives the outputs
// Clock and reset are kept outside the bundle.
// -----------------------------------------------------------------------------
interface updn_if
    import updn_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    state_t           state;
    logic             ovf;
    logic             unf;
    logic             dir_chg;

    modport master (
        output en, up_dn, load, load_val,
        input  count, state, ovf, unf, dir_chg
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, state, ovf, unf, dir_chg
    );

endinterface

// File: rtl/updn_cnt_core.sv
// -----------------------------------------------------------------------------
// updn_cnt_core
// Purely combinational next-count and overflow/underflow computation.
//   count_i    : current registered count
//   en_i       : count enable
//   up_dn_i    : 1 = up, 0 = down
//   load_i     : load strobe (takes priority over en_i)
//   load_val_i : value to load
//   count_o    : next count value
//   ovf_o      : up-count attempted at all-ones
//   unf_o      : down-count attempted at zero
// Build option: UPDN_CNT_SAT_EN selects saturation at the limits instead of
// wrap-around; ovf_o/unf_o flag the attempt in both modes.
// -----------------------------------------------------------------------------
module updn_cnt_core
    import updn_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // WIDTH-bit add/subtract wraps modulo 2^WIDTH on its own.
    logic [WIDTH-1:0] inc_w;
    logic [WIDTH-1:0] dec_w;

    assign inc_w = count_i + ONE;
    assign dec_w = count_i - ONE;

    always_comb begin
        count_o = count_i;
        ovf_o   = 1'b0;
        unf_o   = 1'b0;
        if (load_i) begin
            count_o = load_val_i;
        end else if (en_i) begin
            if (up_dn_i) begin
                if (count_i == MAX_VAL) begin
                    ovf_o = 1'b1;
`ifdef UPDN_CNT_SAT_EN
                    count_o = MAX_VAL;
`else
                    count_o = inc_w;
`endif
                end else begin
                    count_o = inc_w;
                end
            end else begin
                if (count_i == '0) begin
                    unf_o = 1'b1;
`ifdef UPDN_CNT_SAT_EN
                    count_o = '0;
`else
                    count_o = dec_w;
`endif
                end else begin
                    count_o = dec_w;
                end
            end
        end
    end

endmodule

// File: rtl/updn_counter.sv
// -----------------------------------------------------------------------------
// updn_counter
// Loadable up/down counter with a direction-tracking FSM. All outputs are
// registered; one cycle from input to output.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   en       : count enable
//   up_dn    : direction, 1 = up, 0 = down
//   load     : synchronous load strobe (rst > load > en)
//   load_val : value loaded when load = 1
//   count    : registered count
//   state    : registered direction state (updn_pkg::state_t)
//   ovf      : one-cycle pulse, up-count attempted at all-ones
//   unf      : one-cycle pulse, down-count attempted at zero
//   dir_chg  : one-cycle pulse on a direct UP<->DOWN transition
// Build option: UPDN_CNT_SAT_EN (saturate instead of wrap, in updn_cnt_core).
// -----------------------------------------------------------------------------
module updn_counter
    import updn_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output state_t           state,
    output logic             ovf,
    output logic             unf,
    output logic             dir_chg
);

    logic [WIDTH-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             dir_chg_q, dir_chg_d;

    updn_cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .count_i    (count_q),
        .en_i       (en),
        .up_dn_i    (up_dn),
        .load_i     (load),
        .load_val_i (load_val),
        .count_o    (count_d),
        .ovf_o      (ovf_d),
        .unf_o      (unf_d)
    );

    // Direction FSM next state. A load freezes the state; dir_chg only fires
    // when the previous state was the opposite direction, so a pass through
    // HOLD never flags a change.
    always_comb begin
        state_d   = state_q;
        dir_chg_d = 1'b0;
        if (!load) begin
            if (en) begin
                if (up_dn) begin
                    state_d   = UP;
                    dir_chg_d = (state_q == DOWN);
                end else begin
                    state_d   = DOWN;
                    dir_chg_d = (state_q == UP);
                end
            end else if (state_q == UP || state_q == DOWN) begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            state_q   <= IDLE;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            dir_chg_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            dir_chg_q <= dir_chg_d;
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign dir_chg = dir_chg_q;

endmodule

// File: tb/tb_updn_counter.sv
// -----------------------------------------------------------------------------
// tb_updn_counter
// Directed-vector bench for updn_counter (WIDTH = 4). The driver applies one
// vector per cycle on the falling edge and queues the hand-computed result;
// the monitor pops and compares after the following rising edge.
// Honours UPDN_CNT_SAT_EN for the limit cases.
// -----------------------------------------------------------------------------
module tb_updn_counter;
    import updn_pkg::*;

    localparam int W = 4;

    typedef struct {
        int id;
        int cnt;
        int st;
        int ovf;
        int unf;
        int dch;
    } exp_t;

    typedef struct {
        logic rst;
        logic load;
        int   lval;
        logic en;
        logic up;
        int   cnt;
        int   st;
        int   ovf;
        int   unf;
        int   dch;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    updn_if #(.WIDTH(W)) bus ();

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    updn_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.en),
        .up_dn    (bus.up_dn),
        .load     (bus.load),
        .load_val (bus.load_val),
        .count    (bus.count),
        .state    (bus.state),
        .ovf      (bus.ovf),
        .unf      (bus.unf),
        .dir_chg  (bus.dir_chg)
    );

    always #5 clk = ~clk;

`ifdef UPDN_CNT_SAT_EN
    localparam int C10 = 15, C11 = 15, C13 = 0, C14 = 1, O14 = 0;
`else
    localparam int C10 = 0,  C11 = 0,  C13 = 15, C14 = 0, O14 = 1;
`endif

    // rst load lval en up | count state ovf unf dir_chg
    vec_t vecs[] = '{
        '{1, 0, 0,  0, 0,  0,   0, 0, 0, 0},  // 0 reset
        '{0, 0, 0,  1, 1,  1,   1, 0, 0, 0},  // 1 up
        '{0, 0, 0,  1, 1,  2,   1, 0, 0, 0},  // 2 up
        '{0, 0, 0,  1, 1,  3,   1, 0, 0, 0},  // 3 up
        '{0, 0, 0,  1, 0,  2,   2, 0, 0, 1},  // 4 first down: dir change
        '{0, 0, 0,  1, 0,  1,   2, 0, 0, 0},  // 5 down
        '{0, 0, 0,  1, 0,  0,   2, 0, 0, 0},  // 6 down
        '{0, 0, 0,  0, 0,  0,   3, 0, 0, 0},  // 7 DOWN -> HOLD
        '{0, 1, 15, 0, 0,  15,  3, 0, 0, 0},  // 8 load 15, state kept
        '{0, 0, 0,  1, 1,  C10, 1, 1, 0, 0},  // 9 up at max: ovf
        '{0, 0, 0,  0, 0,  C11, 3, 0, 0, 0},  // 10 ovf is a single pulse
        '{0, 1, 0,  0, 0,  0,   3, 0, 0, 0},  // 11 load 0
        '{0, 0, 0,  1, 0,  C13, 2, 0, 1, 0},  // 12 down at 0: unf, HOLD->DOWN no dchg
        '{0, 0, 0,  1, 1,  C14, 1, O14, 0, 1},// 13 DOWN->UP
        '{0, 1, 9,  1, 1,  9,   1, 0, 0, 0},  // 14 load beats en
        '{0, 1, 6,  0, 0,  6,   1, 0, 0, 0},  // 15 load 6
        '{0, 0, 0,  1, 1,  7,   1, 0, 0, 0},  // 16 count to 7
        '{1, 1, 3,  1, 1,  0,   0, 0, 0, 0},  // 17 rst beats load/en
        '{0, 0, 0,  1, 1,  1,   1, 0, 0, 0},  // 18 first count from 0
        '{0, 0, 0,  0, 0,  1,   3, 0, 0, 0},  // 19 UP -> HOLD
        '{0, 0, 0,  0, 1,  1,   3, 0, 0, 0},  // 20 HOLD stays, up_dn ignored
        '{0, 0, 0,  1, 0,  0,   2, 0, 0, 0},  // 21 HOLD->DOWN, no dchg
        '{1, 0, 0,  0, 0,  0,   0, 0, 0, 0},  // 22 reset
        '{0, 0, 0,  0, 0,  0,   0, 0, 0, 0},  // 23 IDLE stays
        '{0, 1, 5,  0, 0,  5,   0, 0, 0, 0},  // 24 load in IDLE
        '{0, 0, 0,  1, 0,  4,   2, 0, 0, 0}   // 25 IDLE->DOWN
    };

    function automatic void chk(string nm, int id, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %0d, expected %0d", id, nm, act, req);
        end
    endfunction

    // Monitor: compares each queued expectation after the capturing edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("count",   e.id, int'(bus.count),   e.cnt);
                chk("state",   e.id, int'(bus.state),   e.st);
                chk("ovf",     e.id, int'(bus.ovf),     e.ovf);
                chk("unf",     e.id, int'(bus.unf),     e.unf);
                chk("dir_chg", e.id, int'(bus.dir_chg), e.dch);
                chk("ovf_unf_excl", e.id, int'(bus.ovf & bus.unf), 0);
            end
        end
    end

    // Driver
    initial begin
        int guard;
        rst          = 1'b0;
        bus.en       = 1'b0;
        bus.up_dn    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst          = vecs[i].rst;
            bus.load     = vecs[i].load;
            bus.load_val = W'(vecs[i].lval);
            bus.en       = vecs[i].en;
            bus.up_dn    = vecs[i].up;
            exp_q.push_back('{i, vecs[i].cnt, vecs[i].st,
                              vecs[i].ovf, vecs[i].unf, vecs[i].dch});
        end
        @(negedge clk);
        rst      = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
